spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_slave_if.sv | 22 ++
 rtl/spi_sync_edge.sv | 19 +
 rtl/spi_slave.sv | 110 +++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI state encoding and mode-bit positions for master and slave
package spi_pkg;
  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;
  localparam int MODE_CPHA = 0;
  localparam int MODE_CPOL = 1;
  typedef logic [1:0] spi_mode_t;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pin bundle with master and slave views
interface spi_slave_if;
  logic sclk_i;
  logic ss_ni;
  logic mosi_i;
  logic miso_o;
  logic miso_en_o;
  modport master (
    output sclk_i,
    output ss_ni,
    output mosi_i,
    input  miso_o,
    input  miso_en_o
  );
  modport slave (
    input  sclk_i,
    input  ss_ni,
    input  mosi_i,
    output miso_o,
    output miso_en_o
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer with rise/fall pulses taken against a third stage
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) s <= {3{RST_VAL}};
    else s <= {s[1:0], d};
  assign q    = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave, all four modes, selectable bit order, back-to-back words with irq/overrun
module spi_slave import spi_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] tx_i,
  output logic [DATA_W-1:0] rx_o,
  output logic              irq_o,
  output logic              ovr_o,
  input  logic              ack_i,
  output logic              busy_o,
  input  logic              cpol_i,
  input  logic              dord_i,
  input  logic              cpha_i,
  spi_slave_if.slave        spi
);
  localparam int CW = $clog2(DATA_W);
  state_t            state;
  spi_mode_t         mode;
  logic [DATA_W-1:0] sr;
  logic [CW-1:0]     bit_cnt;
  logic              smp;
  logic              ss_q;
  logic              ss_rise;
  logic              ss_fall;
  logic              sck_q;
  logic              sck_rise;
  logic              sck_fall;
  logic              mosi_q;
  logic              mosi_rise;
  logic              mosi_fall;
  logic              lead;
  logic              trail;
  logic              done;
  logic              bit_in;
  logic              unused_sync;
  function automatic logic [DATA_W-1:0] sh(input logic [DATA_W-1:0] v, input logic b, input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction
  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (spi.ss_ni),
    .q     (ss_q),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (spi.sclk_i),
    .q     (sck_q),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (spi.mosi_i),
    .q     (mosi_q),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );
  assign unused_sync     = ^{ss_rise, sck_q, mosi_rise, mosi_fall};
  assign mode[MODE_CPOL] = cpol_i;
  assign mode[MODE_CPHA] = cpha_i;
  assign lead            = mode[MODE_CPOL] ? sck_fall : sck_rise;
  assign trail           = mode[MODE_CPOL] ? sck_rise : sck_fall;
  // with trailing-edge sampling the last bit is still on the pin, not in smp
  assign bit_in          = mode[MODE_CPHA] ? mosi_q : smp;
  assign done            = state == ACTIVE && !ss_q && trail && bit_cnt == CW'(DATA_W - 1);
  assign busy_o          = state == ACTIVE;
  assign spi.miso_en_o   = ~ss_q;
  assign spi.miso_o      = dord_i ? sr[0] : sr[DATA_W-1];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state   <= IDLE;
      sr      <= '0;
      rx_o    <= '0;
      bit_cnt <= '0;
      smp     <= 1'b0;
      irq_o   <= 1'b0;
      ovr_o   <= 1'b0;
    end else begin
      irq_o <= done | (irq_o & ~ack_i);
      ovr_o <= (done & irq_o) | (ovr_o & ~ack_i);
      if (ss_q) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else if (state == IDLE) begin
        if (ss_fall) begin
          state   <= ACTIVE;
          sr      <= tx_i;
          bit_cnt <= '0;
        end
      end else if (done) begin
        rx_o    <= sh(sr, bit_in, dord_i);
        sr      <= tx_i;
        bit_cnt <= '0;
      end else if (trail) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (mode[MODE_CPHA]) smp <= mosi_q;
        else sr <= sh(sr, smp, dord_i);
      end else if (lead) begin
        if (!mode[MODE_CPHA]) smp <= mosi_q;
        else if (bit_cnt != '0) sr <= sh(sr, smp, dord_i);
      end
    end
endmodule
